rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader.sv | 242 ++++++++++++++++++++++++
 tb/tb_rom_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// rom_loader: receives a framed byte stream from the host link and
// writes it into the instruction ROM as 32-bit little-endian words.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   rx_data    - incoming byte
//   rx_valid   - rx_data holds a byte
//   rx_ready   - loader accepts a byte this cycle (valid & ready)
//   rom_we     - one-cycle ROM write strobe
//   rom_waddr  - ROM word address
//   rom_wdata  - ROM word data
//   hold_core  - keeps the core in reset while a load runs
//   load_done  - sticky: last load finished with a good checksum
//   load_err   - sticky: last load aborted
//
// Frame: A5, count lo, count hi, count*4 data bytes, checksum byte.
module rom_loader #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_waddr,
    output logic [31:0]       rom_wdata,
    output logic              hold_core,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_e;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [16:0] MAX_CNT = 17'(2 ** ADDR_W);
    localparam logic [7:0] HDR = 8'hA5;
    localparam logic [ADDR_W:0] WONE = 1;
    localparam logic [TW-1:0] TONE = 1;

    state_e state_q, state_d;

    logic              ready_en_q;
    logic [15:0]       count_q, count_d;
    logic [7:0]        xor_q, xor_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [ADDR_W:0]   widx_q, widx_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              acc;
    logic              busy;
    logic              tmo_hit;
    logic              word_end;
    logic              last_word;
    logic [15:0]       cnt_new;
    logic [ADDR_W:0]   widx_inc;
    logic [31:0]       asm_new;

    assign acc       = rx_valid & rx_ready;
    // tmo_q + 1 would reach TIMEOUT_CYC on this edge
    assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign word_end  = (bcnt_q == 2'd3);
    assign cnt_new   = {rx_data, count_q[7:0]};
    assign widx_inc  = widx_q + WONE;
    assign last_word = (17'(widx_inc) == {1'b0, count_q});
    // first byte of a word ends up in bits 7:0 after four shifts
    assign asm_new   = {rx_data, asm_q[31:8]};

    always_comb begin
        busy = 1'b0;
        unique case (state_q)
            S_LEN0, S_LEN1, S_DATA, S_CSUM: busy = 1'b1;
            default:                        busy = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (acc && rx_data == HDR) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (acc)          state_d = S_LEN1;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_LEN1: begin
                if (acc) begin
                    if ({1'b0, cnt_new} > MAX_CNT) state_d = S_ERR;
                    else if (cnt_new == 16'd0)     state_d = S_CSUM;
                    else                           state_d = S_DATA;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DATA: begin
                if (acc) begin
                    if (word_end && last_word) state_d = S_CSUM;
                end else if (tmo_hit) begin
                    state_d = S_ERR;
                end
            end
            S_CSUM: begin
                if (acc)          state_d = (rx_data == xor_q) ? S_DONE : S_ERR;
                else if (tmo_hit) state_d = S_ERR;
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase
    end

    // outputs
    always_comb begin
        rx_ready = 1'b0;
        unique case (state_q)
            S_DONE, S_ERR: rx_ready = 1'b0;
            default:       rx_ready = ready_en_q;
        endcase
    end

    assign rom_we    = we_q;
    assign rom_waddr = waddr_q;
    assign rom_wdata = wdata_q;
    assign hold_core = hold_q;
    assign load_done = done_q;
    assign load_err  = err_q;

    // datapath next-state
    always_comb begin
        count_d = count_q;
        xor_d   = xor_q;
        asm_d   = asm_q;
        bcnt_d  = bcnt_q;
        widx_d  = widx_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        tmo_d   = (busy && !acc) ? tmo_q + TONE : '0;

        if (acc) begin
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == HDR) begin
                        count_d = '0;
                        xor_d   = '0;
                        bcnt_d  = '0;
                        widx_d  = '0;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                S_LEN0: begin
                    count_d[7:0] = rx_data;
                    xor_d        = xor_q ^ rx_data;
                end
                S_LEN1: begin
                    count_d[15:8] = rx_data;
                    xor_d         = xor_q ^ rx_data;
                end
                S_DATA: begin
                    xor_d  = xor_q ^ rx_data;
                    asm_d  = asm_new;
                    bcnt_d = bcnt_q + 2'd1;
                    if (word_end) begin
                        we_d    = 1'b1;
                        wdata_d = asm_new;
                        waddr_d = widx_q[ADDR_W-1:0];
                        widx_d  = widx_inc;
                    end
                end
                default: ;
            endcase
        end

        if (state_d == S_DONE) begin
            done_d = 1'b1;
            hold_d = 1'b0;
        end
        if (state_d == S_ERR) begin
            err_d  = 1'b1;
            hold_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en_q <= 1'b0;
            count_q    <= '0;
            xor_q      <= '0;
            asm_q      <= '0;
            bcnt_q     <= '0;
            widx_q     <= '0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            hold_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            count_q    <= count_d;
            xor_q      <= xor_d;
            asm_q      <= asm_d;
            bcnt_q     <= bcnt_d;
            widx_q     <= widx_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            hold_q     <= hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed frames against a frame-level model of the
// loader; a monitor matches every ROM write against expected words.
module tb_rom_loader;

    localparam int AW  = 12;
    localparam int TMO = 16;

    logic          clk;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          rom_we;
    logic [AW-1:0] rom_waddr;
    logic [31:0]   rom_wdata;
    logic          hold_core;
    logic          load_done;
    logic          load_err;

    rom_loader #(.ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .rom_we    (rom_we),
        .rom_waddr (rom_waddr),
        .rom_wdata (rom_wdata),
        .hold_core (hold_core),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    wr_t           exp_q[$];
    int            errors = 0;
    int            checks = 0;
    int            n_we = 0;
    logic [AW-1:0] last_a;
    logic [31:0]   last_d;
    logic [31:0]   first_d;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Frame-level model: parse bytes, queue the words that must be
    // written, and decide whether the frame ends good. A truncated
    // frame can only end by timeout, so it is never good.
    function automatic void model(input bq_t f, output logic ok,
                                  output logic [7:0] cs);
        int n;
        int cnt;
        int b;
        logic [7:0] x;
        wr_t w;
        n  = f.size();
        ok = 1'b0;
        cs = 8'h00;
        if (n < 3) return;
        cnt = int'({f[2], f[1]});
        x   = f[1] ^ f[2];
        if (cnt > (1 << AW)) return;
        for (int i = 0; i < cnt; i++) begin
            b = 3 + 4 * i;
            if (b + 3 >= n) return;
            w.a = AW'(i);
            w.d = {f[b+3], f[b+2], f[b+1], f[b]};
            x = x ^ f[b] ^ f[b+1] ^ f[b+2] ^ f[b+3];
            exp_q.push_back(w);
        end
        cs = x;
        if (3 + 4 * cnt >= n) return;
        ok = (f[3 + 4 * cnt] == x);
    endfunction

    // called at posedge+1; returns at posedge+1 after acceptance
    task automatic send_byte(input logic [7:0] b);
        int w;
        w = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!rx_ready) begin
            checks++;
            errors++;
            $display("FAIL send: rx_ready low for %0d cycles, need 1", w);
            rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input bq_t f, output logic [7:0] cs);
        logic ok;
        model(f, ok, cs);
        foreach (f[i]) begin
            send_byte(f[i]);
            if (i == 0) begin
                chk("hold after hdr", hold_core, 1'b1);
                chk("done cleared", load_done, 1'b0);
                chk("err cleared", load_err, 1'b0);
            end
        end
        chk("load_done", load_done, ok);
        chk("load_err", load_err, !ok);
        chk("hold end", hold_core, 1'b0);
        chk("ready end", rx_ready, 1'b0);
        chk("writes left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        chk("ready idle", rx_ready, 1'b1);
    endtask

    task automatic chk_reset_vals();
        chk("rst ready", rx_ready, 1'b0);
        chk("rst we", rom_we, 1'b0);
        chk("rst waddr", rom_waddr, '0);
        chk("rst wdata", rom_wdata, 32'h0);
        chk("rst hold", hold_core, 1'b0);
        chk("rst done", load_done, 1'b0);
        chk("rst err", load_err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        bq_t        frm;
        logic [7:0] cs;
        logic       ok;
        int         n0;

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        fork
            forever begin
                wr_t e;
                @(negedge clk);
                if (rom_we === 1'b1) begin
                    if (n_we == 0) first_d = rom_wdata;
                    n_we++;
                    last_a = rom_waddr;
                    last_d = rom_wdata;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stray rom_we: addr %h data %h, none expected",
                                 rom_waddr, rom_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rom_waddr", rom_waddr, e.a);
                        chk("rom_wdata", rom_wdata, e.d);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready after rst", rx_ready, 1'b1);

        // junk in IDLE is dropped
        send_byte(8'h11);
        send_byte(8'h22);
        chk("junk hold", hold_core, 1'b0);

        // good frame; XOR of 02 00 13 00 00 00 93 00 10 00 is 0x92
        n0  = n_we;
        frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        run_frame(frm, cs);
        chk("model csum", cs, 8'h92);
        chk("good nwe", n_we - n0, 2);
        chk("good word0", first_d, 32'h00000013);
        chk("good addr1", last_a, 1);
        chk("good word1", last_d, 32'h00100093);

        // bad checksum: words still written
        n0  = n_we;
        frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
        run_frame(frm, cs);
        chk("bad nwe", n_we - n0, 2);

        // A5 inside data is payload
        frm = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h01};
        run_frame(frm, cs);
        chk("a5 word", last_d, 32'hA5A5A5A5);

        // oversize count 4097
        n0  = n_we;
        frm = '{8'hA5, 8'h01, 8'h10};
        run_frame(frm, cs);
        chk("oversize nwe", n_we - n0, 0);

        // zero count
        n0  = n_we;
        frm = '{8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(frm, cs);
        chk("zero nwe", n_we - n0, 0);

        // timeout after one data byte
        n0  = n_we;
        frm = '{8'hA5, 8'h01, 8'h00, 8'hAA};
        model(frm, ok, cs);
        chk("tmo model", ok, 1'b0);
        foreach (frm[i]) send_byte(frm[i]);
        repeat (TMO - 1) @(posedge clk);
        #1;
        chk("tmo early", load_err, 1'b0);
        chk("tmo hold", hold_core, 1'b1);
        @(posedge clk);
        #1;
        chk("tmo err", load_err, 1'b1);
        chk("tmo done", load_done, 1'b0);
        chk("tmo hold0", hold_core, 1'b0);
        chk("tmo nwe", n_we - n0, 0);
        @(posedge clk);
        #1;

        // reset after two data bytes
        n0 = n_we;
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready rel", rx_ready, 1'b1);
        chk("mid rst nwe", n_we - n0, 0);
        frm = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        run_frame(frm, cs);
        chk("reload nwe", n_we - n0, 2);
        chk("reload addr", last_a, 1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
